// File: rtl/ex_mdu_if.sv
// ex_mdu_if: operand/result bundle between the EX stage and the multiply/divide unit.
//   master (EX stage) drives: flush, op_valid, op, src_a, src_b
//   slave  (ex_mdu)   drives: stall_req, done, hi, lo
interface ex_mdu_if #(
    parameter int DATA_W = 32
);
    logic              flush;
    logic              op_valid;
    logic [2:0]        op;
    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] src_b;
    logic              stall_req;
    logic              done;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;

    modport master (
        output flush, op_valid, op, src_a, src_b,
        input  stall_req, done, hi, lo
    );

    modport slave (
        input  flush, op_valid, op, src_a, src_b,
        output stall_req, done, hi, lo
    );
endinterface

// File: rtl/ex_mdu.sv
// ex_mdu: multiply/divide unit beside the EX-stage ALU, owner of HI/LO.
//   MULT/MULTU complete after MUL_STAGES cycles, DIV/DIVU through a DATA_W-cycle
//   restoring divider, MTHI/MTLO are single-cycle writes.
// Ports:
//   i_clk  - clock, rising edge
//   i_rst  - asynchronous active-high reset
//   mdu    - ex_mdu_if slave: flush/op_valid/op/src_a/src_b in,
//            stall_req (combinational), done, hi, lo (registered) out
//
// state  | meaning
// S_IDLE | waiting for an op; accepts mul/div and MTHI/MTLO
// S_MUL  | product held, counting down remaining multiply latency
// S_DIV  | one quotient bit per cycle, MSB first
// S_DONE | HI/LO carry a fresh result for exactly this cycle
module ex_mdu #(
    parameter int DATA_W     = 32,
    parameter int MUL_STAGES = 2
) (
    input logic     i_clk,
    input logic     i_rst,
    ex_mdu_if.slave mdu
);
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    localparam int CNT_W    = $clog2(DATA_W + MUL_STAGES) + 1;
    localparam int MUL_INIT = (MUL_STAGES > 1) ? MUL_STAGES - 2 : 0;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [2*DATA_W-1:0] r_prod;
    logic [DATA_W-1:0]   r_quo;
    logic [DATA_W-1:0]   r_rem;
    logic [DATA_W-1:0]   r_dvs;
    logic                r_neg_q;
    logic                r_neg_r;
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;
    logic                w_stall;

    logic w_md;
    logic w_is_mul;
    logic w_signed;
    logic w_a_neg;
    logic w_b_neg;
    logic w_div_zero;

    assign w_md       = mdu.op_valid & (mdu.op >= 3'd1) & (mdu.op <= 3'd4);
    assign w_is_mul   = (mdu.op == 3'd1) | (mdu.op == 3'd2);
    assign w_signed   = (mdu.op == 3'd1) | (mdu.op == 3'd3);
    assign w_a_neg    = w_signed & mdu.src_a[DATA_W-1];
    assign w_b_neg    = w_signed & mdu.src_b[DATA_W-1];
    assign w_div_zero = (mdu.src_b == '0);

    // Sign/zero extension to 2*DATA_W makes one truncated multiply serve both MULT and MULTU.
    logic [2*DATA_W-1:0] w_a_ext;
    logic [2*DATA_W-1:0] w_b_ext;
    logic [2*DATA_W-1:0] w_prod;
    assign w_a_ext = {{DATA_W{w_a_neg}}, mdu.src_a};
    assign w_b_ext = {{DATA_W{w_b_neg}}, mdu.src_b};
    assign w_prod  = w_a_ext * w_b_ext;

    logic [DATA_W-1:0] w_a_mag;
    logic [DATA_W-1:0] w_b_mag;
    assign w_a_mag = w_a_neg ? (~mdu.src_a + 1'b1) : mdu.src_a;
    assign w_b_mag = w_b_neg ? (~mdu.src_b + 1'b1) : mdu.src_b;

    // Restoring step; the shifted remainder needs one extra bit before the compare.
    logic [DATA_W:0]   w_rem_sh;
    logic [DATA_W:0]   w_sub;
    logic              w_ge;
    logic [DATA_W-1:0] w_rem_nxt;
    logic [DATA_W-1:0] w_quo_nxt;
    assign w_rem_sh  = {r_rem, r_quo[DATA_W-1]};
    assign w_sub     = w_rem_sh - {1'b0, r_dvs};
    assign w_ge      = ~w_sub[DATA_W];
    assign w_rem_nxt = w_ge ? w_sub[DATA_W-1:0] : w_rem_sh[DATA_W-1:0];
    assign w_quo_nxt = {r_quo[DATA_W-2:0], w_ge};

    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        if (mdu.flush) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_md) begin
                        w_stall = 1'b1;
                        if (w_is_mul)
                            w_state_nxt = (MUL_STAGES == 1) ? S_DONE : S_MUL;
                        else
                            w_state_nxt = w_div_zero ? S_DONE : S_DIV;
                    end
                end
                S_MUL: begin
                    w_stall = 1'b1;
                    if (r_cnt == '0) w_state_nxt = S_DONE;
                end
                S_DIV: begin
                    w_stall = 1'b1;
                    if (r_cnt == '0) w_state_nxt = S_DONE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_prod  <= '0;
            r_quo   <= '0;
            r_rem   <= '0;
            r_dvs   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (!mdu.flush) begin
                case (r_state)
                    S_IDLE: begin
                        if (w_md) begin
                            if (w_is_mul) begin
                                if (MUL_STAGES == 1) begin
                                    r_hi <= w_prod[2*DATA_W-1:DATA_W];
                                    r_lo <= w_prod[DATA_W-1:0];
                                end
                                r_prod <= w_prod;
                                r_cnt  <= CNT_W'(MUL_INIT);
                            end else if (w_div_zero) begin
                                r_hi <= mdu.src_a;
                                r_lo <= '1;
                            end else begin
                                r_quo   <= w_a_mag;
                                r_rem   <= '0;
                                r_dvs   <= w_b_mag;
                                r_neg_q <= w_a_neg ^ w_b_neg;
                                r_neg_r <= w_a_neg;
                                r_cnt   <= CNT_W'(DATA_W - 1);
                            end
                        end else if (mdu.op_valid && mdu.op == 3'd5) begin
                            r_hi <= mdu.src_a;
                        end else if (mdu.op_valid && mdu.op == 3'd6) begin
                            r_lo <= mdu.src_a;
                        end
                    end
                    S_MUL: begin
                        if (r_cnt == '0) begin
                            r_hi <= r_prod[2*DATA_W-1:DATA_W];
                            r_lo <= r_prod[DATA_W-1:0];
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    S_DIV: begin
                        r_rem <= w_rem_nxt;
                        r_quo <= w_quo_nxt;
                        if (r_cnt == '0) begin
                            r_lo <= r_neg_q ? (~w_quo_nxt + 1'b1) : w_quo_nxt;
                            r_hi <= r_neg_r ? (~w_rem_nxt + 1'b1) : w_rem_nxt;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Reset also masks the request so an op still presented during reset cannot hold the pipe.
    assign mdu.stall_req = w_stall & ~i_rst;
    assign mdu.done      = (r_state == S_DONE);
    assign mdu.hi        = r_hi;
    assign mdu.lo        = r_lo;
endmodule
